// File: rtl/fft_ram_writer_pkg.sv
// ---------------------------------------------------------------------------
// fft_pkg
// Shared constants, FSM state type and the address bit-reverse helper for the
// write side of the channel FFT RAM.
// ---------------------------------------------------------------------------
package fft_pkg;

    localparam int N_POINTS = 1024;          // entries per frame
    localparam int ADDR_W   = 10;            // log2(N_POINTS)
    localparam int IN_W     = 16;            // signed input component width
    localparam int OUT_W    = 14;            // signed stored component width
    localparam int SHIFT    = 2;             // arithmetic right shift before saturation
    localparam int CPLX_W   = 2 * OUT_W;     // RAM word {real, imag}

    typedef enum logic [1:0] {
        FILL,
        FLUSH,
        WAIT
    } state_t;

    // Mirror the address bits: natural-order index -> bit-reversed slot.
    function automatic logic [ADDR_W-1:0] bitrev(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] r;
        for (int k = 0; k < ADDR_W; k++) begin
            r[k] = a[ADDR_W-1-k];
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_ram_writer_if.sv
// ---------------------------------------------------------------------------
// fft_ram_writer_if
// Valid/ready stream of complex FFT output samples.
//   in_valid  source -> sink  sample valid
//   in_ready  sink -> source  sink accepts the sample this cycle
//   in_real   source -> sink  signed real component (IN_W)
//   in_imag   source -> sink  signed imaginary component (IN_W)
//   in_last   source -> sink  final sample of the frame
// master = sample source, slave = fft_ram_writer.
// ---------------------------------------------------------------------------
interface fft_ram_writer_if;
    import fft_pkg::*;

    logic                   in_valid;
    logic                   in_ready;
    logic signed [IN_W-1:0] in_real;
    logic signed [IN_W-1:0] in_imag;
    logic                   in_last;

    modport master (output in_valid, output in_real, output in_imag, output in_last,
                    input  in_ready);
    modport slave  (input  in_valid, input  in_real, input  in_imag, input  in_last,
                    output in_ready);
endinterface

// File: rtl/fft_ram_writer_sat_shift.sv
// ---------------------------------------------------------------------------
// sat_shift
// Combinational scaler for one FFT component: arithmetic right shift by SHIFT,
// then saturate to a signed OUT_W result.
//   din   in   IN_W   signed input component
//   dout  out  OUT_W  scaled, saturated component
//   sat   out  1      high when dout was clipped to a rail
// ---------------------------------------------------------------------------
module sat_shift #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 14,
    parameter int SHIFT = 2
) (
    input  logic signed [IN_W-1:0]  din,
    output logic signed [OUT_W-1:0] dout,
    output logic                    sat
);

    localparam logic signed [IN_W-1:0] MAX_V = IN_W'((1 <<< (OUT_W-1)) - 1);
    localparam logic signed [IN_W-1:0] MIN_V = IN_W'(-(1 <<< (OUT_W-1)));

    // Returns {sat_flag, value}.
    function automatic logic [OUT_W:0] sat_fn(input logic signed [IN_W-1:0] s);
        if (s > MAX_V) begin
            return {1'b1, MAX_V[OUT_W-1:0]};
        end else if (s < MIN_V) begin
            return {1'b1, MIN_V[OUT_W-1:0]};
        end
        return {1'b0, s[OUT_W-1:0]};
    endfunction

    logic signed [IN_W-1:0] shifted;
    logic [OUT_W:0]         res;

    assign shifted = din >>> SHIFT;
    assign res     = sat_fn(shifted);
    assign dout    = res[OUT_W-1:0];
    assign sat     = res[OUT_W];

endmodule

// File: rtl/fft_ram_writer.sv
// ---------------------------------------------------------------------------
// fft_ram_writer
// Write side of the channel FFT RAM. Scales each accepted complex sample to
// 14-bit components, writes one N_POINTS-entry frame, then raises fftdone and
// keeps the RAM untouched until the reader reports detectdone (rising edge).
//   clk, reset_n  clock, asynchronous active-low reset
//   s_in          sample stream (fft_ram_writer_if.slave)
//   ramwe/ramwaddr/ramd  registered RAM write port, ramd = {real, imag}
//   fftdone       frame in RAM is valid for the reader
//   detectdone    reader finished its pass
//   frame_err     one-cycle pulse when in_last disagrees with the frame length
//   sat_count     saturated components this frame (sticky at 16'hFFFF)
// Build option: define BITREV_ADDR_EN to write at bitrev(count) instead of
// count, giving the bit-reversed layout the reader de-reverses.
// ---------------------------------------------------------------------------
module fft_ram_writer
    import fft_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset_n,
    fft_ram_writer_if.slave       s_in,
    output logic                  ramwe,
    output logic [ADDR_W-1:0]     ramwaddr,
    output logic [CPLX_W-1:0]     ramd,
    output logic                  fftdone,
    input  logic                  detectdone,
    output logic                  frame_err,
    output logic [15:0]           sat_count
);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   count_q, count_d;
    logic                in_ready_q, in_ready_d;
    logic                ramwe_q, ramwe_d;
    logic [ADDR_W-1:0]   ramwaddr_q, ramwaddr_d;
    logic [CPLX_W-1:0]   ramd_q, ramd_d;
    logic                fftdone_q, fftdone_d;
    logic                frame_err_q, frame_err_d;
    logic [15:0]         sat_count_q, sat_count_d;
    logic                det_q, det_d;

    logic signed [OUT_W-1:0] re_s, im_s;
    logic                    re_sat, im_sat;
    logic                    accept, last_slot;
    logic [16:0]             sat_sum;
    logic [ADDR_W-1:0]       waddr;

    sat_shift #(.IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(SHIFT)) u_sat_re (
        .din (s_in.in_real),
        .dout(re_s),
        .sat (re_sat)
    );

    sat_shift #(.IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(SHIFT)) u_sat_im (
        .din (s_in.in_imag),
        .dout(im_s),
        .sat (im_sat)
    );

`ifdef BITREV_ADDR_EN
    assign waddr = bitrev(count_q);
`else
    assign waddr = count_q;
`endif

    assign accept    = s_in.in_valid && in_ready_q;
    assign last_slot = (count_q == ADDR_W'(N_POINTS - 1));
    assign sat_sum   = {1'b0, sat_count_q} + 17'(re_sat) + 17'(im_sat);

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        ramwe_d     = 1'b0;
        ramwaddr_d  = ramwaddr_q;
        ramd_d      = ramd_q;
        frame_err_d = 1'b0;
        sat_count_d = sat_count_q;
        det_d       = detectdone;

        case (state_q)
            FILL: begin
                if (accept) begin
                    ramwe_d     = 1'b1;
                    ramwaddr_d  = waddr;
                    ramd_d      = {re_s, im_s};
                    sat_count_d = sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
                    // Length mismatch in either direction is flagged; only a
                    // full-length frame ever proceeds to the reader.
                    frame_err_d = s_in.in_last != last_slot;
                    if (last_slot) begin
                        count_d = '0;
                        state_d = FLUSH;
                    end else if (s_in.in_last) begin
                        count_d = '0;
                    end else begin
                        count_d = count_q + ADDR_W'(1);
                    end
                end
            end
            FLUSH: begin
                state_d = WAIT;
            end
            WAIT: begin
                // Edge-triggered release: a detectdone left high from the
                // previous pass must not release a fresh frame.
                if (detectdone && !det_q) begin
                    state_d     = FILL;
                    sat_count_d = '0;
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase

        in_ready_d = (state_d == FILL);
        fftdone_d  = (state_d == WAIT);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= FILL;
            count_q     <= '0;
            in_ready_q  <= 1'b0;
            ramwe_q     <= 1'b0;
            ramwaddr_q  <= '0;
            ramd_q      <= '0;
            fftdone_q   <= 1'b0;
            frame_err_q <= 1'b0;
            sat_count_q <= '0;
            det_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            in_ready_q  <= in_ready_d;
            ramwe_q     <= ramwe_d;
            ramwaddr_q  <= ramwaddr_d;
            ramd_q      <= ramd_d;
            fftdone_q   <= fftdone_d;
            frame_err_q <= frame_err_d;
            sat_count_q <= sat_count_d;
            det_q       <= det_d;
        end
    end

    assign s_in.in_ready = in_ready_q;
    assign ramwe         = ramwe_q;
    assign ramwaddr      = ramwaddr_q;
    assign ramd          = ramd_q;
    assign fftdone       = fftdone_q;
    assign frame_err     = frame_err_q;
    assign sat_count     = sat_count_q;

endmodule
